// File: rtl/fdiv_pkg.sv
// Shared definitions for the divided-tick scheduler.
//   CNT_W_DEF / PULSE_W_DEF : default widths of ratio/phase and npulse/pulse_cnt
//   S_IDLE..S_DONE          : bit positions of the one-hot scheduler state
//   state_e                 : one-hot state encoding built from those positions
package fdiv_pkg;

  localparam int unsigned CNT_W_DEF   = 4;
  localparam int unsigned PULSE_W_DEF = 8;

  localparam int unsigned N_STATES = 4;
  localparam int unsigned S_IDLE   = 0;
  localparam int unsigned S_CLR    = 1;
  localparam int unsigned S_RUN    = 2;
  localparam int unsigned S_DONE   = 3;

  typedef enum logic [N_STATES-1:0] {
    ST_IDLE = 4'(1 << S_IDLE),
    ST_CLR  = 4'(1 << S_CLR),
    ST_RUN  = 4'(1 << S_RUN),
    ST_DONE = 4'(1 << S_DONE)
  } state_e;

endpackage

// File: rtl/fdiv_sched_if.sv
// Control/status bundle between the configuration source and fdiv_sched.
//   start, abort, hold : run control from the source
//   ratio, npulse      : run configuration, latched when start is accepted
//   tick, busy, done   : registered status strobes/levels from the scheduler
//   pulse_cnt          : ticks issued in the current or last run
// master = configuration source side, slave = scheduler side.
interface fdiv_sched_if import fdiv_pkg::*; #(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF
) ();

  logic               start;
  logic               abort;
  logic               hold;
  logic [CNT_W-1:0]   ratio;
  logic [PULSE_W-1:0] npulse;
  logic               tick;
  logic               busy;
  logic               done;
  logic [PULSE_W-1:0] pulse_cnt;

  modport master (
    output start, abort, hold, ratio, npulse,
    input  tick, busy, done, pulse_cnt
  );

  modport slave (
    input  start, abort, hold, ratio, npulse,
    output tick, busy, done, pulse_cnt
  );

endinterface

// File: rtl/fdiv_core.sv
// Generic modulo-N phase counter (divide-by-ratio clock-enable core).
//   clk, rst : clock, synchronous active-high reset
//   clr      : force phase to 0 (wins over c_up)
//   c_up     : advance phase by one this cycle
//   ratio    : modulus N; phase runs 0..N-1
//   phase    : current phase
//   wrap     : combinational, high in the cycle the phase steps from N-1 back to 0
module fdiv_core import fdiv_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             c_up,
  input  logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] phase,
  output logic             wrap
);

  logic [CNT_W-1:0] r_phase;
  logic             w_at_last;

  // Last phase of the period; compare is plain CNT_W-bit unsigned.
  assign w_at_last = (r_phase == CNT_W'(ratio - CNT_W'(1)));
  assign wrap      = c_up & ~clr & w_at_last;
  assign phase     = r_phase;

  // Phase register: clear beats count, wrap returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (clr) begin
      r_phase <= '0;
    end else if (c_up) begin
      if (w_at_last) r_phase <= '0;
      else           r_phase <= r_phase + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fdiv_sched.sv
// Programmable divided-tick scheduler: on an accepted start it clears the
// divider core for one cycle, then steps it and issues npulse one-cycle ticks,
// one per completed divide period. Supports pause (hold) and cancel (abort).
//   clk, rst : clock, synchronous active-high reset
//   bus      : fdiv_sched_if slave port
//              in : start, abort, hold, ratio, npulse
//              out: tick, busy, done, pulse_cnt (all registered)
module fdiv_sched import fdiv_pkg::*; #(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  fdiv_sched_if.slave bus
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_ratio_q;
  logic [PULSE_W-1:0] r_npulse_q;
  logic [PULSE_W-1:0] r_pulse_cnt;
  logic               r_tick;
  logic               r_done;
  logic               r_busy;

  logic               w_clr;
  logic               w_c_up;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_phase;
  logic               w_last_pulse;

  assign w_clr        = r_state[S_CLR];
  assign w_c_up       = r_state[S_RUN] & ~bus.hold;
  assign w_last_pulse = (r_pulse_cnt == PULSE_W'(r_npulse_q - PULSE_W'(1)));

  fdiv_core #(.CNT_W(CNT_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .c_up  (w_c_up),
    .ratio (r_ratio_q),
    .phase (w_phase),
    .wrap  (w_wrap)
  );

  // Scheduler FSM with registered tick/done/busy and the pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ratio_q   <= CNT_W'(1);
      r_npulse_q  <= '0;
      r_pulse_cnt <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            // Ratio 0 or 1 both mean a tick every enabled cycle.
            r_ratio_q   <= (bus.ratio > CNT_W'(1)) ? bus.ratio : CNT_W'(1);
            r_npulse_q  <= bus.npulse;
            r_pulse_cnt <= '0;
            r_busy      <= 1'b1;
            if (bus.npulse == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_CLR;
            end
          end
        end
        ST_CLR: begin
          r_pulse_cnt <= '0;
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort beats a coincident wrap: no tick, no count, no done.
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_tick      <= 1'b1;
            r_pulse_cnt <= r_pulse_cnt + PULSE_W'(1);
            if (w_last_pulse) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The core phase must stay inside the latched period while running.
  always_ff @(posedge clk) begin
    if (!rst && r_state[S_RUN]) assert (w_phase < r_ratio_q);
  end

  assign bus.tick      = r_tick;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_fdiv_sched.sv
module tb_fdiv_sched;

  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fdiv_sched_if #(.CNT_W(CW), .PULSE_W(PW)) bus ();

  fdiv_sched #(.CNT_W(CW), .PULSE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  // Reference model: mode 0 idle, 1 clearing, 2 running, 3 finished.
  // A run counts down the enabled cycles left until the next tick.
  int m_mode   = 0;
  int m_left   = 0;
  int m_ratio  = 1;
  int m_target = 0;
  int e_tick   = 0;
  int e_done   = 0;
  int e_busy   = 0;
  int e_pcnt   = 0;

  // Observations per scenario
  int obs_ticks, obs_dones, first_tick, first_done, start_cyc;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_no);
  endtask

  task automatic model_step(input int r, input int s, input int a, input int h,
                            input int ra, input int np);
    if (r != 0) begin
      m_mode = 0; e_tick = 0; e_done = 0; e_busy = 0; e_pcnt = 0;
      return;
    end
    e_tick = 0;
    e_done = 0;
    case (m_mode)
      0: if (s != 0 && a == 0) begin
           m_ratio  = (ra < 2) ? 1 : ra;
           m_target = np;
           e_pcnt   = 0;
           e_busy   = 1;
           if (np == 0) begin m_mode = 3; e_done = 1; end
           else m_mode = 1;
         end
      1: if (a != 0) begin m_mode = 0; e_busy = 0; end
         else begin m_mode = 2; m_left = m_ratio; end
      2: if (a != 0) begin
           m_mode = 0; e_busy = 0;
         end else if (h == 0) begin
           m_left--;
           if (m_left == 0) begin
             e_tick = 1;
             e_pcnt++;
             m_left = m_ratio;
             if (e_pcnt == m_target) begin m_mode = 3; e_done = 1; end
           end
         end
      default: begin m_mode = 0; e_busy = 0; end
    endcase
  endtask

  // One clock: drive inputs, advance model, sample DUT on the falling edge.
  task automatic cyc(input int r, input int s, input int a, input int h,
                     input int ra, input int np);
    rst        = (r != 0);
    bus.start  = (s != 0);
    bus.abort  = (a != 0);
    bus.hold   = (h != 0);
    bus.ratio  = CW'(ra);
    bus.npulse = PW'(np);
    model_step(r, s, a, h, ra, np);
    @(negedge clk);
    cyc_no++;
    check_eq("tick", int'(bus.tick), e_tick);
    check_eq("done", int'(bus.done), e_done);
    check_eq("busy", int'(bus.busy), e_busy);
    check_eq("pulse_cnt", int'(bus.pulse_cnt), e_pcnt);
    if (bus.tick) begin
      obs_ticks++;
      if (first_tick < 0) first_tick = cyc_no;
    end
    if (bus.done) begin
      obs_dones++;
      if (first_done < 0) first_done = cyc_no;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_obs();
    obs_ticks = 0; obs_dones = 0; first_tick = -1; first_done = -1;
    start_cyc = cyc_no;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 3, 2);

    // ratio 3, two ticks
    clear_obs();
    cyc(0, 1, 0, 0, 3, 2);
    idle(10);
    check_eq("s1_ticks", obs_ticks, 2);
    check_eq("s1_first_tick", first_tick - start_cyc, 5);
    check_eq("s1_done", first_done - start_cyc, 8);

    // ratio 1, four back-to-back ticks
    clear_obs();
    cyc(0, 1, 0, 0, 1, 4);
    idle(8);
    check_eq("s2_ticks", obs_ticks, 4);
    check_eq("s2_first_tick", first_tick - start_cyc, 3);
    check_eq("s2_done", first_done - start_cyc, 6);

    // two hold cycles in the first period
    clear_obs();
    cyc(0, 1, 0, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(12);
    check_eq("s3_ticks", obs_ticks, 3);
    check_eq("s3_first_tick", first_tick - start_cyc, 7);
    check_eq("s3_done", first_done - start_cyc, 13);

    // abort on the second wrap
    clear_obs();
    cyc(0, 1, 0, 0, 4, 5);
    idle(8);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    check_eq("s4_ticks", obs_ticks, 1);
    check_eq("s4_dones", obs_dones, 0);
    check_eq("s4_first_tick", first_tick - start_cyc, 6);

    // npulse 0
    clear_obs();
    cyc(0, 1, 0, 0, 0, 0);
    idle(3);
    check_eq("s5_ticks", obs_ticks, 0);
    check_eq("s5_done", first_done - start_cyc, 1);

    // ratio 0 behaves as ratio 1
    clear_obs();
    cyc(0, 1, 0, 0, 0, 3);
    idle(6);
    check_eq("s6_ticks", obs_ticks, 3);
    check_eq("s6_first_tick", first_tick - start_cyc, 3);
    check_eq("s6_done", first_done - start_cyc, 5);

    // reset mid-run, then starts while busy are ignored
    cyc(0, 1, 0, 0, 5, 4);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0);
    clear_obs();
    cyc(0, 1, 0, 0, 2, 2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 7, 9);
    idle(6);
    check_eq("s7_ticks", obs_ticks, 2);
    check_eq("s7_done", first_done - start_cyc, 6);
    cyc(0, 1, 0, 0, 2, 1);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          int'($urandom_range(0, 6)),
          int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fdiv_sched.md
# fdiv_sched

Programmable divided-tick scheduler. Accepts a start request with a division ratio and a pulse count, clears and then steps a modulo-N divider core, and emits exactly the requested number of one-cycle `tick` strobes spaced `ratio` enabled cycles apart. It supports pause (`hold`) and cancel (`abort`). The block sits between a control/configuration source and the divided-clock-enable consumers, and it owns the `clr`/`c_up` sequencing of its divider core.

## Interface
Parameters:
- `CNT_W`, 4: width of `ratio` and of the core phase counter.
- `PULSE_W`, 8: width of `npulse` and `pulse_cnt`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  cancel run; effective in CLR/RUN.
- `hold`  in  1  pause stepping in RUN (core `c_up` = 0).
- `ratio`  in  CNT_W  division ratio, latched on start accept.
- `npulse`  in  PULSE_W  number of ticks to issue, latched on start accept.
- `tick`  out  1  registered one-cycle strobe per completed divide period.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion flag (DONE state).
- `pulse_cnt`  out  PULSE_W  ticks issued in the current or last run.

## Operation
- State machine (one-hot): IDLE, CLR, RUN, DONE.
- IDLE:
  - `start=1 & abort=0` → latch `ratio_q`, `npulse_q`.
  - Then → CLR if `npulse≠0`; → DONE if `npulse==0` (no ticks issued).
  - `start` while busy: ignored, never queued.
- `ratio_q` rule: latched value 0 or 1 is stored as 1, i.e. a tick every enabled cycle.
- CLR (exactly 1 cycle):
  - core `clr=1`, so phase ← 0.
  - `pulse_cnt` ← 0.
  - → RUN, unless `abort` → IDLE.
- RUN:
  - core `c_up = ~hold`.
  - Phase counts 0..`ratio_q`−1, advancing only when `c_up=1`.
  - wrap `w = RUN & ~hold & (phase == ratio_q−1)`; on `w` the phase returns to 0.
  - `tick <= w & ~abort`.
  - On `w & ~abort`: `pulse_cnt` increments.
  - If `pulse_cnt == npulse_q−1` at the wrap → DONE.
  - `abort` in RUN → IDLE. It has priority over a coincident wrap: no tick, no count, no done.
- DONE (1 cycle): `done=1` → IDLE. `abort`, `hold` and `start` are ignored.
- `pulse_cnt` holds its value in IDLE until the next accepted start.
- Width rules:
  - Phase compare is CNT_W-bit unsigned.
  - `pulse_cnt` cannot overflow, since the run ends at `npulse_q` ≤ 2^PULSE_W−1.
- `rst` at any point, including mid-run, on the next edge:
  - state ← IDLE, phase ← 0.
  - `tick`, `done`, `busy` ← 0; `pulse_cnt` ← 0.
  - No `done` is produced.

## Timing
- Start accepted at edge k: CLR during cycle k+1, RUN from k+2.
- First tick latency, `hold=0`: wrap in cycle k+1+`ratio_q`, `tick` high in cycle k+2+`ratio_q`.
- Subsequent ticks every `ratio_q` cycles. Each cycle with `hold=1` in RUN adds one cycle of delay.
- The final tick and `done` are high in the same cycle. `busy` falls the following cycle.
- Earliest re-start: `start` sampled in the first IDLE cycle after DONE.
- `npulse=0`: `done` in cycle k+1, and no tick.
- Abort sampled at edge m: state is IDLE in cycle m+1, and `tick` stays 0 in cycle m+1.

## Structure
- Shared package `fdiv_pkg`:
  - state index constants `S_IDLE`, `S_CLR`, `S_RUN`, `S_DONE` for the one-hot vector.
  - default `CNT_W`/`PULSE_W` constants.
- Sub-module `fdiv_core`: a generic modulo-N phase counter.
  - inputs `clk`, `rst`, `clr`, `c_up`, `ratio`; outputs `phase`, `wrap`.
  - `clr` has priority over `c_up`.
  - It is the parameterised generalisation of the team's fixed divide-by-3 FSM.
- `fdiv_sched` holds the FSM, the latches, `pulse_cnt`, and the registered `tick`.

## Test plan
- Reset, then `start` with ratio=3, npulse=2, hold=0 (start at edge 0):
  - ticks in cycles 5 and 8, `done` in cycle 8, `busy` low from cycle 9.
  - `pulse_cnt`=2 afterwards.
- ratio=1, npulse=4: ticks in 4 consecutive cycles starting cycle 3; `done` coincides with the 4th tick.
- ratio=3, npulse=3, `hold` high for 2 cycles during the first period:
  - first tick delayed by exactly 2 cycles.
  - later ticks spaced 3 cycles; total ticks = 3.
- `abort` sampled on the same edge as the 2nd wrap (ratio=4, npulse=5):
  - no 2nd tick, no `done`.
  - `pulse_cnt`=1, IDLE the next cycle.
- npulse=0 and ratio=0 start:
  - `done` one cycle after acceptance, zero ticks.
  - a ratio=0 run with npulse=3 behaves as ratio=1.
- `rst` asserted mid-RUN, then `start` re-issued during busy and after IDLE:
  - all outputs reach 0 one edge after `rst`.
  - a `start` issued while busy is ignored; a `start` in IDLE is accepted normally.
